// File: rtl/ob_unpack.sv
// Output-buffer unpacker: pops 32-bit FIFO words, splits them into fp16 pairs
// and assembles PARA-lane vectors for the compute engine, zero-padding the tail.
module ob_unpack #(
  parameter int PARA = 16,
  parameter int LW   = $clog2(PARA) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          op_num,
  output logic                 busy,
  output logic                 done,
  output logic                 ob_re,
  input  logic [31:0]          ob_data,
  input  logic                 ob_valid,
  input  logic                 ob_empty,
  output logic [16*PARA-1:0]   vec_data,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic                 vec_last,
  output logic [LW-1:0]        vec_lanes
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t              state_r;
  logic [15:0]         rem_r;
  logic [LW-1:0]       lane_r;
  logic                busy_r;
  logic                done_r;
  logic                ob_re_r;
  logic [16*PARA-1:0]  vec_data_r;
  logic                vec_valid_r;
  logic                vec_last_r;
  logic [LW-1:0]       vec_lanes_r;

  logic [15:0]         take_s;
  logic [15:0]         rem_nxt_s;
  logic [LW-1:0]       lane_nxt_s;

  // Elements consumed by the word being captured: two, or one for an odd tail.
  always_comb begin
    take_s     = (rem_r >= 16'd2) ? 16'd2 : rem_r;
    rem_nxt_s  = rem_r - take_s;
    lane_nxt_s = lane_r + LW'(take_s);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      rem_r       <= 16'd0;
      lane_r      <= {LW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ob_re_r     <= 1'b0;
      vec_data_r  <= {(16*PARA){1'b0}};
      vec_valid_r <= 1'b0;
      vec_last_r  <= 1'b0;
      vec_lanes_r <= {LW{1'b0}};
    end else begin
      done_r  <= 1'b0;
      ob_re_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (op_num != 16'd0) begin
              rem_r      <= op_num;
              lane_r     <= {LW{1'b0}};
              vec_data_r <= {(16*PARA){1'b0}};
              busy_r     <= 1'b1;
              state_r    <= REQ;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!ob_empty) begin
            ob_re_r <= 1'b1;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (ob_valid) begin
            // lane_r is always even here, so lane_r+1 stays inside the vector.
            for (int i = 0; i < PARA; i++) begin
              if (LW'(i) == lane_r) begin
                vec_data_r[16*i +: 16] <= ob_data[15:0];
              end else if ((LW'(i) == (lane_r + LW'(1))) && (rem_r >= 16'd2)) begin
                vec_data_r[16*i +: 16] <= ob_data[31:16];
              end
            end
            rem_r  <= rem_nxt_s;
            lane_r <= lane_nxt_s;
            if ((lane_nxt_s == LW'(PARA)) || (rem_nxt_s == 16'd0)) begin
              vec_valid_r <= 1'b1;
              vec_lanes_r <= lane_nxt_s;
              vec_last_r  <= (rem_nxt_s == 16'd0);
              state_r     <= OUT;
            end else begin
              state_r <= REQ;
            end
          end
        end
        OUT: begin
          if (vec_ready) begin
            vec_valid_r <= 1'b0;
            vec_last_r  <= 1'b0;
            vec_lanes_r <= {LW{1'b0}};
            vec_data_r  <= {(16*PARA){1'b0}};
            lane_r      <= {LW{1'b0}};
            state_r     <= (rem_r == 16'd0) ? FIN : REQ;
          end
        end
        FIN: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign ob_re     = ob_re_r;
  assign vec_data  = vec_data_r;
  assign vec_valid = vec_valid_r;
  assign vec_last  = vec_last_r;
  assign vec_lanes = vec_lanes_r;

endmodule

// File: tb/tb_ob_unpack.sv
// Self-checking bench for ob_unpack: FIFO model with random latency, random
// backpressure, and a vector scoreboard built from the element-stream rules.
module tb_ob_unpack;

  localparam int PARA = 16;
  localparam int LW   = $clog2(PARA) + 1;
  localparam int VW   = 16 * PARA;

  typedef struct {
    logic [VW-1:0] data;
    logic [LW-1:0] lanes;
    logic          last;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [15:0]    op_num = 16'd0;
  logic           busy, done, ob_re;
  logic [31:0]    ob_data = 32'd0;
  logic           ob_valid = 1'b0;
  logic           ob_empty = 1'b1;
  logic [VW-1:0]  vec_data;
  logic           vec_valid;
  logic           vec_ready = 1'b0;
  logic           vec_last;
  logic [LW-1:0]  vec_lanes;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] wbuf[$];
  vec_t        exp_q[$];
  int          re_cnt = 0, done_cnt = 0, vec_cnt = 0, pend_cnt = 0;
  logic [31:0] pend_word = 32'd0;
  int          max_lat = 0, rdy_mode = 0;
  bit          spur_en = 1'b0, rnd_empty = 1'b0, hold_empty = 1'b0, mon_en = 1'b0;

  ob_unpack #(.PARA(PARA), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .op_num(op_num),
    .busy(busy), .done(done), .ob_re(ob_re), .ob_data(ob_data),
    .ob_valid(ob_valid), .ob_empty(ob_empty), .vec_data(vec_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_last(vec_last),
    .vec_lanes(vec_lanes)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: one word per ob_re, delivered 1+lat cycles later; optional
  // spurious ob_valid whenever no read is outstanding.
  initial begin
    forever begin
      @(negedge clk);
      ob_valid = 1'b0;
      ob_data  = $urandom;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          ob_valid = 1'b1;
          ob_data  = pend_word;
        end
      end else if (spur_en && !ob_re && ($urandom_range(0, 3) == 0)) begin
        ob_valid = 1'b1;
      end
      if (ob_re && reset) begin
        re_cnt++;
        check_eq("re_while_empty", ob_empty, 0);
        if (fifo_q.size() > 0) pend_word = fifo_q.pop_front();
        else pend_word = 32'hDEAD_BEEF;
        pend_cnt = 1 + $urandom_range(0, max_lat);
      end
      ob_empty = (fifo_q.size() == 0) || hold_empty || (rnd_empty && ($urandom_range(0, 2) == 0));
    end
  end

  // Consumer ready driver: 0 = always ready, 1 = random, other = stalled.
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: vec_ready = 1'b1;
        1: vec_ready = 1'($urandom_range(0, 1));
        default: vec_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: every valid cycle must show the head expected vector.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (done) done_cnt++;
        if (vec_valid) begin
          check_eq("no_re_in_out", ob_re, 0);
          if (exp_q.size() == 0) begin
            check_eq("unexpected_vec", vec_valid, 0);
          end else begin
            check_eq("vec_data", vec_data, exp_q[0].data);
            check_eq("vec_lanes", vec_lanes, exp_q[0].lanes);
            check_eq("vec_last", vec_last, exp_q[0].last);
            if (vec_ready) begin
              void'(exp_q.pop_front());
              vec_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic run_op(input int n);
    int   nvec, b, e, rem;
    vec_t v;
    logic [31:0] w;
    re_cnt = 0; done_cnt = 0; vec_cnt = 0;
    foreach (wbuf[i]) fifo_q.push_back(wbuf[i]);
    nvec = (n + PARA - 1) / PARA;
    for (int k = 0; k < nvec; k++) begin
      rem     = n - k * PARA;
      v.data  = '0;
      v.lanes = LW'((rem < PARA) ? rem : PARA);
      v.last  = (k == nvec - 1);
      for (int j = 0; j < PARA; j++) begin
        e = k * PARA + j;
        if (e < n) begin
          w = wbuf[e / 2];
          v.data[16*j +: 16] = (e % 2 == 1) ? w[31:16] : w[15:0];
        end
      end
      exp_q.push_back(v);
    end
    @(negedge clk);
    start = 1'b1; op_num = 16'(n);
    @(negedge clk);
    start = 1'b0; op_num = 16'($urandom);
    #1;
    check_eq("busy_after_start", busy, (n > 0));
    if (n == 0) check_eq("zero_done_next", done, 1);
    if (n >= 4) begin
      @(negedge clk);
      start = 1'b1; op_num = 16'd3;
      @(negedge clk);
      start = 1'b0;
    end
    for (b = 0; b < 4000 && done_cnt == 0; b++) begin
      @(negedge clk);
      #1;
    end
    check_eq("done_seen", (done_cnt > 0), 1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("done_once", done_cnt, 1);
    check_eq("busy_after_done", busy, 0);
    check_eq("re_count", re_cnt, (n + 1) / 2);
    check_eq("vec_count", vec_cnt, nvec);
    check_eq("exp_drained", exp_q.size(), 0);
    wbuf.delete();
  endtask

  task automatic fill_random(input int nw);
    wbuf.delete();
    for (int i = 0; i < nw; i++) wbuf.push_back($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, n;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ob_re", ob_re, 0);
    check_eq("rst_vec_valid", vec_valid, 0);
    check_eq("rst_vec_last", vec_last, 0);
    check_eq("rst_vec_data", vec_data, 0);
    check_eq("rst_vec_lanes", vec_lanes, 0);
    @(negedge clk);
    reset = 1'b1; mon_en = 1'b1;

    // Ascending pattern: one full vector.
    wbuf.delete();
    for (int i = 0; i < 8; i++) wbuf.push_back({16'(2*i + 2), 16'(2*i + 1)});
    run_op(16);

    // Odd count: upper half of the last word is dropped, lanes 5.. are zero.
    wbuf.delete();
    wbuf.push_back(32'hBBBB_AAAA);
    wbuf.push_back(32'hDDDD_CCCC);
    wbuf.push_back(32'hFFFF_EEEE);
    run_op(5);

    // Three vectors: 16, 16, 8 lanes.
    fill_random(20);
    run_op(40);

    // Zero-length op.
    run_op(0);

    // Empty stall in REQ.
    fill_random(4);
    hold_empty = 1'b1;
    fork
      run_op(8);
      begin
        for (b = 0; b < 50 && !busy; b++) begin
          @(negedge clk);
          #1;
        end
        repeat (6) begin
          @(negedge clk);
          #1;
          check_eq("stall_no_re", ob_re, 0);
        end
        #1 hold_empty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("re_after_empty", ob_re, 1);
      end
    join

    // Backpressure on the first vector.
    fill_random(20);
    rdy_mode = 2;
    fork
      run_op(40);
      begin
        for (b = 0; b < 400 && !vec_valid; b++) begin
          @(negedge clk);
          #1;
        end
        repeat (10) begin
          @(negedge clk);
          #1;
          check_eq("bp_valid", vec_valid, 1);
          if (exp_q.size() > 0) check_eq("bp_data", vec_data, exp_q[0].data);
          check_eq("bp_lanes", vec_lanes, PARA);
          check_eq("bp_no_re", ob_re, 0);
        end
        #1 rdy_mode = 0;
        @(negedge clk);
        #1;
        check_eq("bp_pre_handshake", vec_valid, 1);
        @(negedge clk);
        #1;
        check_eq("bp_resume", vec_valid, 0);
      end
    join

    // Reset during WAIT of the third word, then a clean op.
    mon_en = 1'b0;
    fill_random(8);
    foreach (wbuf[i]) fifo_q.push_back(wbuf[i]);
    re_cnt = 0;
    @(negedge clk);
    start = 1'b1; op_num = 16'd16;
    @(negedge clk);
    start = 1'b0;
    for (b = 0; b < 200 && re_cnt < 3; b++) begin
      @(negedge clk);
      #1;
    end
    #1 reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_ob_re", ob_re, 0);
    check_eq("mid_rst_vec_valid", vec_valid, 0);
    check_eq("mid_rst_vec_last", vec_last, 0);
    check_eq("mid_rst_vec_data", vec_data, 0);
    check_eq("mid_rst_vec_lanes", vec_lanes, 0);
    fifo_q.delete(); pend_cnt = 0; exp_q.delete(); wbuf.delete();
    @(negedge clk);
    reset = 1'b1; mon_en = 1'b1;
    wbuf.push_back(32'h2222_1111);
    wbuf.push_back(32'h4444_3333);
    wbuf.push_back(32'h6666_5555);
    run_op(6);

    // Randomized ops with latency, spurious valids, empty toggling, backpressure.
    spur_en = 1'b1; rnd_empty = 1'b1; rdy_mode = 1;
    for (int t = 0; t < 10; t++) begin
      if (t == 0) n = 1;
      else if (t == 1) n = 33;
      else n = $urandom_range(1, 70);
      max_lat = $urandom_range(0, 4);
      fill_random((n + 1) / 2);
      run_op(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
